bank_scheduler: RTL

BANK_SCHEDULER -- requirements
Module: bank_scheduler

---
 rtl/bank_scheduler_pkg.sv | 35 +++
 rtl/bank_scheduler_bank_timer.sv | 36 +++
 rtl/bank_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/bank_scheduler_pkg.sv
// Shared constants and request decoding for the banked scheduler.
package bank_scheduler_pkg;

  localparam int NUM_BANKS           = 4;
  localparam int BANK_W              = 2;
  localparam int READ_LAT            = 2;
  localparam int DEFAULT_BUSY_CYCLES = 4;
  // Wide enough for the largest legal BUSY_CYCLES-1 (7).
  localparam int TIMER_W             = 4;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_READ    = 2'd1,
    REQ_WRITE   = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_kind_e;

  // Classify one cycle's request: both strobes, or a single strobe with an
  // odd byte address, is illegal.
  function automatic req_kind_e decode_req(input logic rd, input logic wr,
                                           input logic a0);
    req_kind_e kind;
    kind = REQ_NONE;
    if (rd && wr)
      kind = REQ_ILLEGAL;
    else if ((rd || wr) && a0)
      kind = REQ_ILLEGAL;
    else if (rd)
      kind = REQ_READ;
    else if (wr)
      kind = REQ_WRITE;
    return kind;
  endfunction

endpackage

// File: rtl/bank_scheduler_bank_timer.sv
// Per-bank occupancy timer: loaded on acceptance, counts down to idle.
module bank_timer
  import bank_scheduler_pkg::*;
#(
  parameter int BUSY_CYCLES = DEFAULT_BUSY_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Load BUSY_CYCLES-1 so the bank reads busy for exactly the cycles after
  // acceptance and frees itself in the BUSY_CYCLES-th cycle.
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = TIMER_W'(BUSY_CYCLES - 1);
    else if (count_q != '0)
      count_d = count_q - 1'b1;
  end

  // Counter register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/bank_scheduler.sv
// Four-bank memory front end: per-bank occupancy, fixed 2-cycle read latency.
module bank_scheduler
  import bank_scheduler_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BUSY_CYCLES = DEFAULT_BUSY_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int DEPTH = 1 << IDX_W;

  req_kind_e           req_kind;
  logic [BANK_W-1:0]   bank;
  logic [IDX_W-1:0]    idx;
  logic                legal;
  logic                accept;
  logic [NUM_BANKS-1:0] load;

  // Word storage; the bank field sits inside the word index.
  logic [DATA_W-1:0]   mem [DEPTH];

  // Stage 1 carries the accepted read's index; stage 2 carries the data out.
  logic                rd_v_q,     rd_v_d;
  logic [IDX_W-1:0]    rd_idx_q,   rd_idx_d;
  logic                valid_q,    valid_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                err_q,      err_d;

  assign req_kind = decode_req(rd, wr, addr[0]);
  assign bank     = addr[BANK_W:1];
  assign idx      = addr[ADDR_W-1:1];
  assign legal    = (req_kind == REQ_READ) || (req_kind == REQ_WRITE);
  assign stall    = legal && busy[bank];
  assign accept   = legal && !busy[bank];

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign load[gi] = accept && (bank == BANK_W'(gi));
      bank_timer #(.BUSY_CYCLES(BUSY_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load[gi]),
        .busy (busy[gi])
      );
    end
  endgenerate

  // Storage write on the acceptance edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept && (req_kind == REQ_WRITE))
      mem[idx] <= data_in;
  end

  // Next-state for the read pipeline, output data hold and error pulse.
  always_comb begin
    rd_v_d     = accept && (req_kind == REQ_READ);
    rd_idx_d   = rd_v_d ? idx : rd_idx_q;
    valid_d    = rd_v_q;
    data_out_d = rd_v_q ? mem[rd_idx_q] : data_out_q;
    err_d      = (req_kind == REQ_ILLEGAL);
  end

  // Pipeline and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v_q     <= 1'b0;
      rd_idx_q   <= '0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_v_q     <= rd_v_d;
      rd_idx_q   <= rd_idx_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_out_q;
  assign err      = err_q;

endmodule
